iq_boxcar_decimator: RTL and testbench
======================================

Name: iq_boxcar_decimator

Overview:
- Downstream consumer of the IQ demodulator's 24-bit baseband outputs.
- Integrate-and-dump low-pass/decimator: sums 2^k consecutive qualified I and Q samples, then emits their arithmetic mean once per frame with a one-cycle valid strobe.
- Decimation exponent k is runtime-selectable and latched per frame, so upstream tuning or rate changes never corrupt a partial frame.

Parameters:
- DATA_W, 24, sample width (signed two's complement) for inputs and outputs.
- LOG2_DECIM_MAX, 6, largest supported k; decimation range 1..64.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_valid  in  1  qualifies i_in/q_in this cycle (driven by demod enable_out)
- i_in  in  DATA_W  in-phase sample, signed
- q_in  in  DATA_W  quadrature sample, signed
- decim_log2  in  3  requested k; sampled only at frame start
- clear  in  1  synchronous frame abort
- i_out  out  DATA_W  averaged I, signed
- q_out  out  DATA_W  averaged Q, signed
- out_valid  out  1  one-cycle strobe; i_out/q_out are new
- frame_active  out  1  high while a partial frame is accumulated (count != 0)

Behaviour:
- Reset (asynchronous, reset_n=0): i_acc=q_acc=0, count=0, k_lat=0, i_out=q_out=0, out_valid=0, frame_active=0. Reset mid-frame discards partial sums with no output strobe.
- Accumulators: width DATA_W+LOG2_DECIM_MAX, inputs sign-extended, no saturation needed (overflow impossible by width).
- Clamping: decim_log2 values above LOG2_DECIM_MAX are clamped to LOG2_DECIM_MAX.
- States: IDLE (count=0) and ACCUM (count>0). frame_active = (state==ACCUM).
- IDLE with sample_valid=1:
  - k_lat <= clamp(decim_log2); acc <= sample.
  - If clamp(decim_log2)==0: frame completes immediately (pass-through); stay IDLE and dump.
  - Otherwise count <= 1 and go to ACCUM.
- ACCUM with sample_valid=1:
  - If count == 2^k_lat - 1: dump, count <= 0, go to IDLE.
  - Otherwise acc += sample, count++.
- sample_valid=0: no state change (gaps of any length are allowed inside a frame).
- Dump (registered, same edge as last sample accepted):
  - i_out <= (i_acc + i_in) >>> k_lat, truncated to DATA_W; same for Q.
  - Arithmetic shift, i.e. rounding toward minus infinity.
  - out_valid <= 1 for exactly that cycle, and 0 on every other cycle.
- Latency: out_valid is asserted in the cycle after the clock edge that captured the frame's final sample.
- Holding: i_out/q_out hold their value between strobes.
- clear=1 (has priority over sample_valid): acc <= 0, count <= 0, go to IDLE, no strobe.
  - A sample presented in the same cycle as clear is dropped.
  - Outputs hold their last value.
- Rate changes: decim_log2 changes while in ACCUM are ignored until the next frame start.
- Back-to-back frames: continuous sample_valid=1 yields out_valid every 2^k cycles with no lost samples. The first sample of frame n+1 is accepted in the cycle immediately after the dump edge of frame n.

Test Plan:
- Reset, then k=2 with valid I inputs 4, 8, 12, 16 (Q = negatives) -> one strobe, i_out=10, q_out=-10, frame_active low afterward.
- k=0 with I = 100, -7, 5 on consecutive cycles -> three consecutive strobes, i_out equals each input one cycle later.
- k=3 with I=-1 for 8 samples and sample_valid toggled 1/0 -> exactly one strobe after the 8th valid sample, i_out=-1. Then I = -1,0,0,0,0,0,0,0 -> i_out=-1 (floor of -1/8).
- Full scale, k=6: 64 samples of I=0x7FFFFF and Q=0x800000 -> i_out=0x7FFFFF, q_out=0x800000 (no overflow). decim_log2=7 behaves as 6.
- Mid-frame events, k=2 (after 2 samples):
  - decim_log2 changed to 1 -> frame still ends after 4 samples; the next frame is 2 samples.
  - Separately, clear asserted with sample_valid=1 -> no strobe, next 4 samples 1,1,1,1 -> i_out=1.
- reset_n pulsed low asynchronously mid-frame (between edges) -> all outputs 0 immediately, no strobe. The next full frame averages correctly.

Source files
------------

// File: rtl/iq_boxcar_decimator.sv
// ---------------------------------------------------------------------------
// iq_boxcar_decimator
//
// Integrate-and-dump decimator for the IQ demodulator's baseband outputs.
// Sums 2^k qualified I/Q samples and emits their floor-mean once per frame
// with a one-cycle strobe. k is latched at the first sample of each frame so
// rate changes never corrupt a partial frame.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   sample_valid  qualifies i_in/q_in this cycle
//   i_in, q_in    signed input samples (DATA_W)
//   decim_log2    requested k, sampled only at frame start (clamped)
//   clear         synchronous frame abort, overrides sample_valid
//   i_out, q_out  signed averaged outputs, held between strobes
//   out_valid     one-cycle strobe marking new i_out/q_out
//   frame_active  high while a partial frame is being accumulated
// ---------------------------------------------------------------------------
module iq_boxcar_decimator #(
   parameter int DATA_W         = 24,
   parameter int LOG2_DECIM_MAX = 6
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     sample_valid,
   input  logic signed [DATA_W-1:0] i_in,
   input  logic signed [DATA_W-1:0] q_in,
   input  logic [2:0]               decim_log2,
   input  logic                     clear,
   output logic signed [DATA_W-1:0] i_out,
   output logic signed [DATA_W-1:0] q_out,
   output logic                     out_valid,
   output logic                     frame_active
);

   localparam int ACC_W = DATA_W + LOG2_DECIM_MAX;
   localparam int CNT_W = (LOG2_DECIM_MAX > 0) ? LOG2_DECIM_MAX : 1;
   localparam int KW    = (LOG2_DECIM_MAX > 0) ? $clog2(LOG2_DECIM_MAX + 1) : 1;
   localparam int LEN_W = CNT_W + 1;

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                    state_q;
   logic signed [ACC_W-1:0]   i_acc_q, q_acc_q;
   logic        [CNT_W-1:0]   count_q;
   logic        [KW-1:0]      k_lat_q;
   logic signed [DATA_W-1:0]  i_out_q, q_out_q;
   logic                      out_valid_q;

   logic        [KW-1:0]      k_req_d, k_use_d;
   logic signed [ACC_W-1:0]   i_ext_d, q_ext_d, i_sum_d, q_sum_d;
   logic        [LEN_W-1:0]   frame_len_d;
   logic                      last_d;
   logic signed [DATA_W-1:0]  i_mean_d, q_mean_d;

   function automatic logic [KW-1:0] clamp_k(input logic [2:0] k);
      if (int'(k) > LOG2_DECIM_MAX) return KW'(LOG2_DECIM_MAX);
      else                          return KW'(k);
   endfunction

   // Arithmetic shift gives the mean rounded toward minus infinity; the
   // result always fits DATA_W because it is an average of DATA_W samples.
   function automatic logic signed [DATA_W-1:0] mean_floor(
      input logic signed [ACC_W-1:0] sum,
      input logic [KW-1:0]           k
   );
      logic signed [ACC_W-1:0] sh;
      sh = sum >>> k;
      return sh[DATA_W-1:0];
   endfunction

   always_comb begin
      k_req_d = clamp_k(decim_log2);
      // In IDLE the incoming sample starts the frame, so the freshly clamped
      // k applies (matters only for k=0 pass-through) and the old sum is void.
      k_use_d = (state_q == IDLE) ? k_req_d : k_lat_q;
      i_ext_d = {{LOG2_DECIM_MAX{i_in[DATA_W-1]}}, i_in};
      q_ext_d = {{LOG2_DECIM_MAX{q_in[DATA_W-1]}}, q_in};
      i_sum_d = ((state_q == ACCUM) ? i_acc_q : '0) + i_ext_d;
      q_sum_d = ((state_q == ACCUM) ? q_acc_q : '0) + q_ext_d;
      i_mean_d = mean_floor(i_sum_d, k_use_d);
      q_mean_d = mean_floor(q_sum_d, k_use_d);
      frame_len_d = LEN_W'(1) << k_lat_q;
      last_d = ({1'b0, count_q} == (frame_len_d - LEN_W'(1)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         i_acc_q     <= '0;
         q_acc_q     <= '0;
         count_q     <= '0;
         k_lat_q     <= '0;
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (clear) begin
            // Abort: drop partial frame and any sample on this cycle.
            state_q <= IDLE;
            i_acc_q <= '0;
            q_acc_q <= '0;
            count_q <= '0;
         end else if (sample_valid) begin
            case (state_q)
               IDLE: begin
                  k_lat_q <= k_req_d;
                  i_acc_q <= i_ext_d;
                  q_acc_q <= q_ext_d;
                  if (k_req_d == '0) begin
                     i_out_q     <= i_mean_d;
                     q_out_q     <= q_mean_d;
                     out_valid_q <= 1'b1;
                  end else begin
                     count_q <= CNT_W'(1);
                     state_q <= ACCUM;
                  end
               end
               ACCUM: begin
                  if (last_d) begin
                     i_out_q     <= i_mean_d;
                     q_out_q     <= q_mean_d;
                     out_valid_q <= 1'b1;
                     i_acc_q     <= '0;
                     q_acc_q     <= '0;
                     count_q     <= '0;
                     state_q     <= IDLE;
                  end else begin
                     i_acc_q <= i_sum_d;
                     q_acc_q <= q_sum_d;
                     count_q <= count_q + CNT_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign i_out        = i_out_q;
   assign q_out        = q_out_q;
   assign out_valid    = out_valid_q;
   assign frame_active = (state_q == ACCUM);

endmodule

// File: tb/tb_iq_boxcar_decimator.sv
module tb_iq_boxcar_decimator;

   localparam int DATA_W = 24;
   localparam int LMAX   = 6;

   logic                     clk = 1'b0;
   logic                     reset_n;
   logic                     sample_valid;
   logic signed [DATA_W-1:0] i_in, q_in;
   logic [2:0]               decim_log2;
   logic                     clear;
   logic signed [DATA_W-1:0] i_out, q_out;
   logic                     out_valid;
   logic                     frame_active;

   int vectors     = 0;
   int miscompares = 0;

   logic [2*DATA_W-1:0] exp_q[$];
   logic [2*DATA_W-1:0] obs_q[$];
   logic [2*DATA_W-1:0] e, o;

   // reference model state
   longint m_si, m_sq;
   int     m_cnt, m_k;
   logic signed [DATA_W-1:0] m_last_i, m_last_q;

   iq_boxcar_decimator #(.DATA_W(DATA_W), .LOG2_DECIM_MAX(LMAX)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .i_in         (i_in),
      .q_in         (q_in),
      .decim_log2   (decim_log2),
      .clear        (clear),
      .i_out        (i_out),
      .q_out        (q_out),
      .out_valid    (out_valid),
      .frame_active (frame_active)
   );

   always #5 clk = ~clk;

   // capture every strobe for the scoreboard
   always @(negedge clk) if (reset_n === 1'b1 && out_valid === 1'b1) obs_q.push_back({i_out, q_out});

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic longint floor_div(input longint s, input longint n);
      longint r;
      r = s / n;
      if ((s % n != 0) && (s < 0)) r = r - 1;
      return r;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_si = 0; m_sq = 0; m_k = 0;
   endtask

   // Drive one cycle of stimulus; update the model and push expected results.
   task automatic send(input logic v, input int i, input int q, input logic clr = 1'b0);
      sample_valid = v;
      i_in  = DATA_W'(i);
      q_in  = DATA_W'(q);
      clear = clr;
      if (clr) begin
         m_cnt = 0; m_si = 0; m_sq = 0;
      end else if (v) begin
         if (m_cnt == 0) m_k = (decim_log2 > 3'(LMAX)) ? LMAX : int'(decim_log2);
         m_si += i;
         m_sq += q;
         m_cnt++;
         if (m_cnt == (1 << m_k)) begin
            m_last_i = DATA_W'(floor_div(m_si, longint'(m_cnt)));
            m_last_q = DATA_W'(floor_div(m_sq, longint'(m_cnt)));
            exp_q.push_back({m_last_i, m_last_q});
            m_cnt = 0; m_si = 0; m_sq = 0;
         end
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      clear        = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sample_valid = 1'b0; clear = 1'b0;
      i_in = '0; q_in = '0; decim_log2 = 3'd0;
      model_reset();
      #2;
      vectors++; if (i_out !== '0) begin miscompares++; $display("FAIL reset_i_out: got %0d want 0", i_out); end
      vectors++; if (q_out !== '0) begin miscompares++; $display("FAIL reset_q_out: got %0d want 0", q_out); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL reset_frame_active: got %b want 0", frame_active); end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_average_k2();
      decim_log2 = 3'd2;
      send(1, 4, -4);
      send(1, 8, -8);
      vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL k2_frame_active_mid: got %b want 1", frame_active); end
      send(1, 12, -12);
      send(1, 16, -16);
      vectors++; if (out_valid !== 1'b1 || i_out !== 24'sd10 || q_out !== -24'sd10) begin
         miscompares++; $display("FAIL k2_strobe: got v=%b i=%0d q=%0d want v=1 i=10 q=-10", out_valid, i_out, q_out);
      end
      vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL k2_frame_active_end: got %b want 0", frame_active); end
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL k2_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL k2_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL k2_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_passthrough();
      int pv[3];
      pv = '{100, -7, 5};
      decim_log2 = 3'd0;
      for (int n = 0; n < 3; n++) begin
         send(1, pv[n], -pv[n]);
         vectors++; if (out_valid !== 1'b1 || i_out !== DATA_W'(pv[n]) || q_out !== DATA_W'(-pv[n])) begin
            miscompares++; $display("FAIL pass_%0d: got v=%b i=%0d q=%0d want v=1 i=%0d q=%0d", n, out_valid, i_out, q_out, pv[n], -pv[n]);
         end
      end
      send(0, 0, 0);
      vectors++; if (out_valid !== 1'b0 || frame_active !== 1'b0) begin miscompares++; $display("FAIL pass_idle: got v=%b fa=%b want 0 0", out_valid, frame_active); end
      send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL pass_sb: got no strobe, want i=%0d", $signed(e[2*DATA_W-1:DATA_W])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL pass_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL pass_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_gapped();
      decim_log2 = 3'd3;
      for (int n = 0; n < 8; n++) begin
         send(1, -1, 3);
         send(0, 1000, -1000);
      end
      for (int n = 0; n < 8; n++) send(1, (n == 0) ? -1 : 0, (n == 0) ? 7 : 0);
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL gap_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL gap_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL gap_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_full_scale();
      decim_log2 = 3'd6;
      for (int n = 0; n < 63; n++) send(1, 32'h007F_FFFF, -32'sd8388608);
      vectors++; if (frame_active !== 1'b1 || obs_q.size() != 0) begin
         miscompares++; $display("FAIL fs_no_early_strobe: got fa=%b strobes=%0d want fa=1 strobes=0", frame_active, obs_q.size());
      end
      send(1, 32'h007F_FFFF, -32'sd8388608);
      decim_log2 = 3'd7;
      for (int n = 0; n < 64; n++) send(1, n, -n);
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL fs_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL fs_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL fs_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_rate_change();
      decim_log2 = 3'd2;
      send(1, 1, -1);
      send(1, 2, -2);
      decim_log2 = 3'd1;
      send(1, 3, -3);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rate_no_early_strobe: got %b want 0", out_valid); end
      send(1, 4, -4);
      send(1, 5, -5);
      send(1, 6, -6);
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL rate_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL rate_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL rate_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_clear();
      decim_log2 = 3'd2;
      send(1, 7, 7);
      send(1, 7, 7);
      send(1, 9, 9, 1'b1);
      vectors++; if (out_valid !== 1'b0 || frame_active !== 1'b0) begin
         miscompares++; $display("FAIL clear_state: got v=%b fa=%b want 0 0", out_valid, frame_active);
      end
      vectors++; if (i_out !== m_last_i || q_out !== m_last_q) begin
         miscompares++; $display("FAIL clear_hold: got i=%0d q=%0d want i=%0d q=%0d", i_out, q_out, m_last_i, m_last_q);
      end
      for (int n = 0; n < 4; n++) send(1, 1, 1);
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL clear_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL clear_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL clear_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_async_reset();
      decim_log2 = 3'd2;
      send(1, 50, -50);
      send(1, 60, -60);
      vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL areset_pre_fa: got %b want 1", frame_active); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (i_out !== '0 || q_out !== '0) begin miscompares++; $display("FAIL areset_outputs: got i=%0d q=%0d want 0 0", i_out, q_out); end
      vectors++; if (out_valid !== 1'b0 || frame_active !== 1'b0) begin miscompares++; $display("FAIL areset_flags: got v=%b fa=%b want 0 0", out_valid, frame_active); end
      model_reset();
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      send(1, 2, -2);
      send(1, 4, -4);
      send(1, 6, -6);
      send(1, 8, -8);
      repeat (2) send(0, 0, 0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); vectors++;
         if (obs_q.size() == 0) begin miscompares++; $display("FAIL areset_sb: got no strobe, want i=%0d q=%0d", $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end
         else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL areset_sb: got i=%0d q=%0d want i=%0d q=%0d", $signed(o[2*DATA_W-1:DATA_W]), $signed(o[DATA_W-1:0]), $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0])); end end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL areset_extra_strobes: got %0d want 0", obs_q.size()); obs_q.delete(); end
   endtask

   initial begin
      test_reset();
      test_average_k2();
      test_passthrough();
      test_gapped();
      test_full_scale();
      test_rate_change();
      test_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
